// File: rtl/mul_iter_unit.sv
// mul_iter_unit: iterative 32x32 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are converted to magnitudes on accept. One partial product is added
// per CALC cycle for 32 cycles. A FIXUP cycle then restores the sign.
// An accept at edge N gives o_valid sampled high at edge N+34.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_valid/o_ready   request handshake (o_ready only in IDLE)
//   i_op              00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_rs1, i_rs2      multiplicand / multiplier
//   o_valid/i_ready   result handshake (o_valid only in DONE)
//   o_result          low half for MUL, high half otherwise
//   o_busy            high whenever the unit is not IDLE
module mul_iter_unit #(
  parameter int unsigned XLEN = 32  // only 32 is supported
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int unsigned CNT_W  = $clog2(XLEN);
  localparam int unsigned PROD_W = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]       r_op;
  logic [XLEN-1:0]  r_mcand;   // |rs1|
  logic [XLEN-1:0]  r_acc_hi;  // high product half
  logic [XLEN-1:0]  r_mplier;  // |rs2|; product low half fills in from the top
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;

  logic             w_accept;
  logic             w_rs1_neg;
  logic             w_rs2_neg;
  logic [XLEN-1:0]  w_mag1;
  logic [XLEN-1:0]  w_mag2;
  logic [XLEN-1:0]  w_addend;
  logic [XLEN:0]    w_sum;     // bit XLEN is the carry-out of the accumulator add
  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] w_prod_neg;

  assign w_accept = i_valid && (r_state == S_IDLE);

  // A source counts as negative only when its op treats it as signed.
  assign w_rs1_neg = ((i_op == OP_MULH) || (i_op == OP_MULHSU)) && i_rs1[XLEN-1];
  assign w_rs2_neg = (i_op == OP_MULH) && i_rs2[XLEN-1];

  // The magnitude of the most negative value wraps back to itself. This is still
  // correct as an unsigned magnitude.
  assign w_mag1 = w_rs1_neg ? (~i_rs1 + XLEN'(1)) : i_rs1;
  assign w_mag2 = w_rs2_neg ? (~i_rs2 + XLEN'(1)) : i_rs2;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_sum      = {1'b0, r_acc_hi} + {1'b0, w_addend};
  assign w_prod     = {r_acc_hi, r_mplier};
  assign w_prod_neg = ~w_prod + PROD_W'(1);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_valid) w_next = S_CALC;
      S_CALC:  if (r_cnt == CNT_LAST) w_next = S_FIXUP;
      S_FIXUP: w_next = S_DONE;
      S_DONE:  if (i_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state and the held product.
  always_comb begin
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    o_busy   = 1'b1;
    o_result = '0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
      end
      S_DONE: begin
        o_valid  = 1'b1;
        o_result = (r_op == OP_MUL) ? r_mplier : r_acc_hi;
      end
      default: ;
    endcase
  end

  // Datapath: load on accept, shift-add in CALC, sign restore in FIXUP
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op     <= '0;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= i_op;
            r_mcand  <= w_mag1;
            r_mplier <= w_mag2;
            r_acc_hi <= '0;
            r_cnt    <= '0;
            r_neg    <= w_rs1_neg ^ w_rs2_neg;
          end
        end
        S_CALC: begin
          r_acc_hi <= w_sum[XLEN:1];
          r_mplier <= {w_sum[0], r_mplier[XLEN-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        S_FIXUP: begin
          if (r_neg) begin
            r_acc_hi <= w_prod_neg[PROD_W-1:XLEN];
            r_mplier <= w_prod_neg[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Self-checking bench for mul_iter_unit: directed vector table, backpressure,
// mid-operation reset and a random sweep against a 64-bit reference product.
module tb_mul_iter_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stall;
    bit          poke;
  } vec_t;

  vec_t vecs[11];

  mul_iter_unit #(.XLEN(32)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ae;
    logic [63:0] be;
    logic [63:0] p;
    bit s1;
    bit s2;
    s1 = (op == 2'b01) || (op == 2'b10);
    s2 = (op == 2'b01);
    ae = s1 ? {{32{a[31]}}, a} : {32'h0, a};
    be = s2 ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ae * be;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Entered and left at a negedge, so successive calls issue back-to-back requests.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int stall, input bit poke,
                        input string tag);
    int cnt;
    logic [31:0] held;
    logic [31:0] e;
    check({tag, " ready"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    i_ready = 1'b0;
    @(posedge i_clk);
    exp_q.push_back(exp);
    cnt = 0;
    do begin
      @(negedge i_clk);
      cnt++;
      i_valid = 1'b0;
      if (poke) begin
        i_valid = 1'($urandom_range(0, 1));
        i_op    = 2'($urandom_range(0, 3));
        i_rs1   = $urandom;
        i_rs2   = $urandom;
      end
    end while (!o_valid && cnt < 100);
    i_valid = 1'b0;
    e = exp_q.pop_front();
    if (!o_valid) begin
      check({tag, " valid_timeout"}, 32'(o_valid), 32'd1);
      return;
    end
    check({tag, " latency"}, 32'(cnt), 32'd34);
    held = o_result;
    for (int s = 0; s < stall; s++) begin
      @(negedge i_clk);
      check({tag, " stall_valid"}, 32'(o_valid), 32'd1);
      check({tag, " stall_result"}, o_result, held);
    end
    check({tag, " result"}, o_result, e);
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
    check({tag, " valid_drop"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0]  = '{2'b00, 32'h00000007, 32'h00000006, 32'h0000002A, 0, 1'b0};
    vecs[1]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 0, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1'b0};
    vecs[3]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0};
    vecs[4]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0, 1'b0};
    vecs[5]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 0, 1'b0};
    vecs[6]  = '{2'b01, 32'h00000000, 32'h80000000, 32'h00000000, 0, 1'b0};
    vecs[7]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h00000000, 0, 1'b0};
    vecs[8]  = '{2'b01, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 0, 1'b0};
    vecs[9]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1'b0};
    vecs[10] = '{2'b00, 32'h00000003, 32'h00000005, 32'h0000000F, 5, 1'b1};

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_op    = 2'b00;
    i_rs1   = '0;
    i_rs2   = '0;
    i_ready = 1'b0;
    #2;
    check("rst ready", 32'(o_ready), 32'd1);
    check("rst valid", 32'(o_valid), 32'd0);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst result", o_result, 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall, vecs[i].poke,
             $sformatf("vec%0d", i));
    end

    // Reset in the middle of CALC must drop the in-flight operation.
    i_valid = 1'b1;
    i_op    = 2'b00;
    i_rs1   = 32'd7;
    i_rs2   = 32'd9;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    check("midcalc busy", 32'(o_busy), 32'd1);
    check("midcalc ready", 32'(o_ready), 32'd0);
    #1;
    i_rst = 1'b1;
    #1;
    check("async_rst ready", 32'(o_ready), 32'd1);
    check("async_rst valid", 32'(o_valid), 32'd0);
    check("async_rst busy", 32'(o_busy), 32'd0);
    check("async_rst result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    run_op(2'b00, 32'd3, 32'd5, 32'h0000000F, 0, 1'b0, "post_rst");

    // Random sweep with corner-biased operands and occasional short stalls.
    for (int n = 0; n < 1000; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       a = 32'h80000000;
        1:       a = 32'hFFFFFFFF;
        2:       a = 32'h00000000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'h80000000;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'h7FFFFFFF;
        default: b = $urandom;
      endcase
      run_op(op, a, b, ref_mul(op, a, b), $urandom_range(0, 2), 1'b0,
             $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_iter_unit.md
MUL_ITER_UNIT -- requirements
Module: mul_iter_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  request valid from issue stage.
REQ-005 SHALL have port o_ready  output  1  unit can accept a request.
REQ-006 SHALL have port i_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 SHALL have port i_rs1  input  32  multiplicand source (rs1).
REQ-008 SHALL have port i_rs2  input  32  multiplier source (rs2).
REQ-009 SHALL have port o_valid  output  1  result valid to writeback.
REQ-010 SHALL have port i_ready  input  1  writeback accepts result.
REQ-011 SHALL have port o_result  output  32  selected product half.
REQ-012 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIXUP, DONE.
REQ-014 SHALL drive o_ready=1 only in IDLE; accept occurs on an edge where i_valid && o_ready.
REQ-015 SHALL on accept latch i_op, compute operand signedness: rs1 signed for MULH/MULHSU, rs2 signed for MULH only; MUL treated unsigned (low half identical).
REQ-016 SHALL on accept load magnitudes |rs1|, |rs2| as 32-bit unsigned (0x80000000 stays 0x80000000), clear 33-bit high accumulator, clear 5-bit iteration counter, record neg = sign(rs1)^sign(rs2) for signed operands, then enter CALC.
REQ-017 SHALL in each CALC cycle: if multiplier LSB=1, add magnitude(rs1) to accumulator high 32 bits via 32-bit add with carry-out; shift {carry, acc_hi, multiplier} right by one; increment counter.
REQ-018 SHALL perform exactly 32 CALC cycles (counter 0..31) with no early termination; after counter=31 enter FIXUP.
REQ-019 SHALL in FIXUP two's-complement negate the 64-bit product when neg=1, else hold it; then enter DONE.
REQ-020 SHALL in DONE drive o_valid=1 and o_result = product[31:0] for MUL, product[63:32] otherwise, both held stable until i_ready=1.
REQ-021 SHALL on a DONE edge with i_ready=1 return to IDLE; o_valid deasserts next cycle; next accept no earlier than the following edge.
REQ-022 SHALL have fixed latency: accept at edge N -> o_valid high from edge N+34.
REQ-023 SHALL ignore i_valid and input values while not in IDLE; latched operands are unaffected by input changes.
REQ-024 SHALL produce zero product when either operand is zero (no special path; normal 34-cycle latency).

Reset
REQ-025 SHALL on i_rst=1, regardless of clock, force IDLE, o_valid=0, o_busy=0, o_ready=1 (combinational from state), o_result=0, accumulator, multiplier, counter, neg, op registers cleared.
REQ-026 SHALL on reset mid-CALC/FIXUP/DONE discard the in-flight operation with no o_valid pulse.
REQ-027 SHALL accept a new request on the first rising edge after i_rst deasserts.

Verification
REQ-028 SHALL cover MUL 0x00000007 x 0x00000006 -> o_result=0x0000002A, o_valid at accept+34.
REQ-029 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-030 SHALL cover MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULH 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF; MUL same -> 0xFFFFFFFE.
REQ-031 SHALL cover backpressure: i_ready=0 for 5 cycles in DONE -> o_valid and o_result stable; i_valid pulses during CALC ignored.
REQ-032 SHALL cover async reset asserted mid-CALC (cycle 10) -> immediate IDLE, o_valid never rises, o_ready=1; next request 3x5 -> 0x0000000F.
REQ-033 SHALL cover random signed/unsigned sweep (>=1000 ops, all i_op) against a 64-bit reference model, with back-to-back requests.
